// File: rtl/histogram_ctrl.sv
// histogram_ctrl: runs one measurement frame over a single-port bin RAM.
// A frame clears every bin, accumulates SAMPLES inputs through read-modify-write
// increments, then streams every bin out over a valid/ready interface.
module histogram_ctrl #(
  parameter int ADDR_W  = 7,
  parameter int SIZE    = 7,
  parameter int RD_LAT  = 2,
  parameter int SAMPLES = 100
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_bin,
  output logic [SIZE-1:0]   m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              sat_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SIZE-1:0]   mem_wdata,
  output logic              mem_wren,
  input  logic [SIZE-1:0]   mem_rdata
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLEAR    = 3'd1;
  localparam logic [2:0] ST_ACC_WAIT = 3'd2;
  localparam logic [2:0] ST_ACC_RD   = 3'd3;
  localparam logic [2:0] ST_ACC_WR   = 3'd4;
  localparam logic [2:0] ST_RO_RD    = 3'd5;
  localparam logic [2:0] ST_RO_OUT   = 3'd6;

  localparam int CNT_W = $clog2(SAMPLES + 1);

  localparam logic [ADDR_W-1:0] LAST_BIN    = '1;
  localparam logic [SIZE-1:0]   MAX_COUNT   = '1;
  localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(SAMPLES - 1);
  // Increment path: RD_LAT cycles in ACC_RD, so the last one is RD_LAT-1.
  localparam logic [2:0]        ACC_LAT_END = 3'(RD_LAT - 1);
  // Readout: address is driven from the first RO_RD cycle and the data is
  // valid RD_LAT cycles later, so it is sampled at the end of cycle RD_LAT.
  localparam logic [2:0]        RO_LAT_END  = 3'(RD_LAT);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_reg;    // clear address, sample bin, or readout bin
  logic [2:0]        lat_cnt;
  logic [CNT_W-1:0]  sample_cnt;
  logic              sat_hit;

  assign sat_hit  = (mem_rdata == MAX_COUNT);
  assign mem_addr = addr_reg;
  assign busy     = (state != ST_IDLE);
  assign s_ready  = (state == ST_ACC_WAIT);
  assign m_last   = m_valid && (m_bin == LAST_BIN);

  // RAM write port: zeros during CLEAR, saturating increment during ACC_WR.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    mem_wren  = 1'b0;
    mem_wdata = '0;
    case (state)
      ST_CLEAR: begin
        mem_wren = 1'b1;
      end
      ST_ACC_WR: begin
        mem_wren  = 1'b1;
        mem_wdata = sat_hit ? mem_rdata : mem_rdata + SIZE'(1);
      end
      default: ;
    endcase
  end

  // Frame sequencer with synchronous reset; the bin RAM itself is never reset.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (RST) begin
      // NOTE: RAM contents are not reset here; CLEAR rewrites every bin at frame start.
      state      <= ST_IDLE;
      addr_reg   <= '0;
      lat_cnt    <= '0;
      sample_cnt <= '0;
      m_bin      <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      done       <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_CLEAR;
            addr_reg   <= '0;
            sample_cnt <= '0;
            sat_flag   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          // Address wraps back to 0 after the last bin.
          addr_reg <= addr_reg + ADDR_W'(1);
          if (addr_reg == LAST_BIN) state <= ST_ACC_WAIT;
        end
        ST_ACC_WAIT: begin
          if (s_valid) begin
            addr_reg <= s_data;
            lat_cnt  <= '0;
            state    <= ST_ACC_RD;
          end
        end
        ST_ACC_RD: begin
          if (lat_cnt == ACC_LAT_END) begin
            lat_cnt <= '0;
            state   <= ST_ACC_WR;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_ACC_WR: begin
          if (sat_hit) sat_flag <= 1'b1;
          if (sample_cnt == LAST_SAMPLE) begin
            sample_cnt <= '0;
            addr_reg   <= '0;
            lat_cnt    <= '0;
            state      <= ST_RO_RD;
          end else begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            state      <= ST_ACC_WAIT;
          end
        end
        ST_RO_RD: begin
          if (lat_cnt == RO_LAT_END) begin
            lat_cnt <= '0;
            m_data  <= mem_rdata;
            m_bin   <= addr_reg;
            m_valid <= 1'b1;
            state   <= ST_RO_OUT;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_RO_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (addr_reg == LAST_BIN) begin
              done     <= 1'b1;
              addr_reg <= '0;
              state    <= ST_IDLE;
            end else begin
              addr_reg <= addr_reg + ADDR_W'(1);
              state    <= ST_RO_RD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_ctrl.sv
// tb_histogram_ctrl: two controllers (100 and 130 samples per frame), each on
// its own behavioural RAM with a 2-cycle read latency, driven by a frame table.
module tb_histogram_ctrl;

  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  logic            RST;
  logic [1:0]      start, s_valid, m_ready;
  logic [1:0][6:0] s_data;
  wire  [1:0]      busy, done, s_ready, m_valid, m_last, sat_flag, mem_wren;
  wire  [1:0][6:0] m_bin, m_data, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always_ff @(posedge clk_50) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [6:0] ram [128];
    logic [6:0] pipe0, pipe1;

    histogram_ctrl #(
      .ADDR_W(7), .SIZE(7), .RD_LAT(2), .SAMPLES(g == 0 ? 100 : 130)
    ) dut (
      .CLK(clk_50), .RST(RST), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .s_data(s_data[g]), .s_valid(s_valid[g]), .s_ready(s_ready[g]),
      .m_bin(m_bin[g]), .m_data(m_data[g]), .m_valid(m_valid[g]), .m_ready(m_ready[g]),
      .m_last(m_last[g]), .sat_flag(sat_flag[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_wren(mem_wren[g]),
      .mem_rdata(mem_rdata[g])
    );

    // RAM model: data for an address appears two cycles after it is presented.
    always_ff @(posedge clk_50) begin
      if (mem_wren[g]) ram[mem_addr[g]] <= mem_wdata[g];
      pipe0 <= mem_addr[g];
      pipe1 <= pipe0;
    end
    assign mem_rdata[g] = ram[pipe1];
  end

  typedef struct {
    int         dut;
    logic [6:0] val_a;      // first n_a samples
    logic [6:0] val_b;      // remaining samples
    int         n_a;
    int         ready_pct;  // m_ready probability
    logic [6:0] exp_a;      // expected count of bin val_a
    logic [6:0] exp_b;      // expected count of bin val_b
    logic       exp_sat;
  } frame_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_bin(input frame_vec_t v, input int k);
    if (k == int'(v.val_a)) return v.exp_a;
    if (k == int'(v.val_b)) return v.exp_b;
    return 7'd0;
  endfunction

  task automatic run_frame(input frame_vec_t v);
    int d       = v.dut;
    int samples = (d == 0) ? 100 : 130;
    int clear_bad = 0;
    int sp_bad    = 0;
    int last_acc  = 0;
    int budget;
    int k  = 0;
    int it = 0;
    logic stalled = 1'b0;
    logic [6:0] held_bin  = '0;
    logic [6:0] held_data = '0;

    // Start with s_valid already high: nothing may be accepted during CLEAR.
    @(negedge clk_50);
    start[d]   = 1'b1;
    s_valid[d] = 1'b1;
    s_data[d]  = (v.n_a > 0) ? v.val_a : v.val_b;
    @(negedge clk_50);
    start[d] = 1'b0;
    for (int i = 0; i < 128; i++) begin
      if (mem_wren[d] !== 1'b1 || mem_wdata[d] !== 7'd0 || mem_addr[d] !== 7'(i) ||
          s_ready[d] !== 1'b0 || busy[d] !== 1'b1)
        clear_bad++;
      @(negedge clk_50);
    end
    check("clear_sequence_bad_cycles", clear_bad, 0);
    check("s_ready_after_clear", s_ready[d], 1);

    // Accumulate: s_valid stays high, data changes only between accepts.
    for (int n = 0; n < samples; n++) begin
      s_data[d] = (n < v.n_a) ? v.val_a : v.val_b;
      budget = 0;
      while (!s_ready[d] && budget < 20) begin
        @(negedge clk_50);
        budget++;
      end
      if (!s_ready[d]) begin
        check("accept_timeout_sample", n, samples);
        break;
      end
      if (n > 0 && cyc - last_acc != 4) sp_bad++;
      last_acc = cyc;
      start[d] = (n == 10);  // must be ignored while busy
      @(negedge clk_50);
      start[d] = 1'b0;
      if (mem_wren[d] !== 1'b0) sp_bad++;  // first ACC_RD cycle never writes
    end
    s_valid[d] = 1'b0;
    check("accept_spacing_bad", sp_bad, 0);

    // Readout with random backpressure and a stray start pulse.
    while (k < 128 && it < 5000) begin
      start[d] = (it == 200);
      if (m_valid[d]) begin
        if (stalled) begin
          check("stall_bin_stable", m_bin[d], held_bin);
          check("stall_data_stable", m_data[d], held_data);
        end
        m_ready[d] = ($urandom_range(99, 0) < v.ready_pct);
        if (m_ready[d]) begin
          check($sformatf("ro_bin_order_%0d", k), m_bin[d], k);
          check($sformatf("ro_data_bin_%0d", k), m_data[d], exp_bin(v, k));
          check($sformatf("ro_last_bin_%0d", k), m_last[d], (k == 127));
          k++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_bin  = m_bin[d];
          held_data = m_data[d];
        end
      end else begin
        m_ready[d] = ($urandom_range(99, 0) < v.ready_pct);
      end
      @(negedge clk_50);
      it++;
    end
    start[d]   = 1'b0;
    m_ready[d] = 1'b0;
    check("readout_words", k, 128);
    check("done_pulse", done[d], 1);
    check("idle_after_done", busy[d], 0);
    check("m_valid_after_done", m_valid[d], 0);
    check("sat_flag", sat_flag[d], v.exp_sat);
    @(negedge clk_50);
    check("done_one_cycle", done[d], 0);
    check("still_idle_after_stray_start", busy[d], 0);
  endtask

  frame_vec_t frames [6];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    frames[0] = '{dut: 0, val_a: 7'd5,   val_b: 7'd5,   n_a: 100, ready_pct: 30,  exp_a: 7'd100, exp_b: 7'd100, exp_sat: 1'b0};
    frames[1] = '{dut: 0, val_a: 7'd10,  val_b: 7'd20,  n_a: 40,  ready_pct: 100, exp_a: 7'd40,  exp_b: 7'd60,  exp_sat: 1'b0};
    frames[2] = '{dut: 0, val_a: 7'd0,   val_b: 7'd127, n_a: 1,   ready_pct: 60,  exp_a: 7'd1,   exp_b: 7'd99,  exp_sat: 1'b0};
    frames[3] = '{dut: 1, val_a: 7'd3,   val_b: 7'd3,   n_a: 130, ready_pct: 100, exp_a: 7'd127, exp_b: 7'd127, exp_sat: 1'b1};
    frames[4] = '{dut: 1, val_a: 7'd7,   val_b: 7'd8,   n_a: 65,  ready_pct: 30,  exp_a: 7'd65,  exp_b: 7'd65,  exp_sat: 1'b0};
    frames[5] = '{dut: 1, val_a: 7'd126, val_b: 7'd127, n_a: 128, ready_pct: 50,  exp_a: 7'd127, exp_b: 7'd2,   exp_sat: 1'b1};

    RST = 1'b1;
    start = '0; s_valid = '0; m_ready = '0; s_data = '0;
    repeat (3) @(negedge clk_50);
    RST = 1'b0;
    @(negedge clk_50);
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", busy[d], 0);
      check("rst_done", done[d], 0);
      check("rst_s_ready", s_ready[d], 0);
      check("rst_m_valid", m_valid[d], 0);
      check("rst_sat_flag", sat_flag[d], 0);
      check("rst_mem_wren", mem_wren[d], 0);
      check("rst_mem_addr", mem_addr[d], 0);
      check("rst_mem_wdata", mem_wdata[d], 0);
    end

    // Reset in the middle of ACC_RD.
    start[0] = 1'b1; s_valid[0] = 1'b1; s_data[0] = 7'd9;
    @(negedge clk_50);
    start[0] = 1'b0;
    repeat (128) @(negedge clk_50);
    check("pre_reset_s_ready", s_ready[0], 1);
    @(negedge clk_50);
    s_valid[0] = 1'b0;
    check("pre_reset_in_acc_rd", s_ready[0] == 1'b0 && busy[0] == 1'b1, 1);
    RST = 1'b1;
    @(negedge clk_50);
    RST = 1'b0;
    check("midframe_rst_busy", busy[0], 0);
    check("midframe_rst_mem_wren", mem_wren[0], 0);
    check("midframe_rst_s_ready", s_ready[0], 0);
    check("midframe_rst_m_valid", m_valid[0], 0);
    check("midframe_rst_mem_addr", mem_addr[0], 0);
    repeat (2) @(negedge clk_50);
    check("midframe_rst_stays_idle", busy[0], 0);

    for (int f = 0; f < 6; f++) run_frame(frames[f]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
